mem_bus_sequencer: RTL

- Multi-cycle controller that runs the single-cycle datapath over one shared Avalon-style memory bus.
- Fetches each instruction, then performs that instruction's data load/store if it has one.
- Holds the fetched word stable and pulses clk_enable for exactly one commit cycle per instruction.
- Detects halt (jump to address 0) and drives the active flag.

---
 rtl/mem_bus_pkg.sv | 19 +
 rtl/store_lane_align.sv | 30 +++
 rtl/mem_bus_sequencer.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the multi-cycle memory bus sequencer.
package mem_bus_pkg;

  typedef enum logic [2:0] {
    RESET_S = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    MEM     = 3'd3,
    COMMIT  = 3'd4,
    HALTED  = 3'd5
  } seq_state_t;

  localparam logic [1:0] SZ_WORD = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_BYTE = 2'b10;

  localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;

endpackage

// File: rtl/store_lane_align.sv
// Store lane steering: places store data on the addressed byte lanes and
// builds the matching byteenable. Misaligned halves/words are not trapped.
module store_lane_align
  import mem_bus_pkg::*;
(
  input  logic [1:0]  store_size,
  input  logic [1:0]  addr,
  input  logic [31:0] dp_writedata,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata
);

  always_comb begin
    bus_byteenable = 4'hF;
    bus_writedata  = dp_writedata;
    case (store_size)
      SZ_HALF: begin
        bus_byteenable = addr[1] ? 4'b1100 : 4'b0011;
        bus_writedata  = addr[1] ? {dp_writedata[15:0], 16'h0000}
                                 : {16'h0000, dp_writedata[15:0]};
      end
      SZ_BYTE: begin
        bus_byteenable = 4'b0001 << addr;
        bus_writedata  = {24'h000000, dp_writedata[7:0]} << {addr, 3'b000};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_bus_sequencer.sv
// Multi-cycle fetch/load/store sequencer over one shared Avalon-style bus.
// Optional bus timeout watchdog: define MEM_BUS_TIMEOUT_EN.
module mem_bus_sequencer
  import mem_bus_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = RESET_VECTOR_DEF,
  parameter int          TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  input  logic [31:0] dp_data_address,
  input  logic [31:0] dp_writedata,
  input  logic        mem_read_req,
  input  logic        mem_write_req,
  input  logic [1:0]  store_size,
  output logic [31:0] instr_readdata,
  output logic [31:0] data_readdata,
  output logic        clk_enable,
  output logic        active,
  output logic [31:0] bus_address,
  output logic        bus_read,
  output logic        bus_write,
  output logic [3:0]  bus_byteenable,
  output logic [31:0] bus_writedata,
  input  logic        bus_waitrequest,
  input  logic [31:0] bus_readdata,
  output logic        timeout_err
);

  seq_state_t  r_state;
  logic [31:0] r_instr, r_data;
  logic        r_clk_en, r_active;
  logic        w_halt, w_to;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_wd;

  // The datapath sets its PC only from RESET_VECTOR; it is carried here for configuration symmetry.
  logic w_unused_cfg;
  assign w_unused_cfg = ^RESET_VECTOR;

  // A committed jump to 0 shows up on pc_in during the following FETCH.
  assign w_halt = (pc_in == 32'h0);

  store_lane_align u_align (
    .store_size     (store_size),
    .addr           (dp_data_address[1:0]),
    .dp_writedata   (dp_writedata),
    .bus_byteenable (w_st_be),
    .bus_writedata  (w_st_wd)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= RESET_S;
      r_instr  <= '0;
      r_data   <= '0;
      r_clk_en <= 1'b0;
      r_active <= 1'b0;
    end else begin
      r_clk_en <= 1'b0;
      if (w_to) begin
        r_state  <= HALTED;
        r_active <= 1'b0;
      end else begin
        case (r_state)
          RESET_S: begin
            r_state  <= FETCH;
            r_active <= 1'b1;
          end
          FETCH:
            if (w_halt) begin
              r_state  <= HALTED;
              r_active <= 1'b0;
            end else if (!bus_waitrequest) begin
              r_instr <= bus_readdata;
              r_state <= DECODE;
            end
          DECODE:
            if (mem_read_req || mem_write_req) r_state <= MEM;
            else begin
              r_state  <= COMMIT;
              r_clk_en <= 1'b1;
            end
          MEM:
            if (!bus_waitrequest) begin
              if (mem_read_req) r_data <= bus_readdata;
              r_state  <= COMMIT;
              r_clk_en <= 1'b1;
            end
          COMMIT:  r_state <= FETCH;
          default: r_state <= HALTED;
        endcase
      end
    end
  end

  // Bus drive is decoded from the state register; inputs feeding it are
  // held by the datapath until clk_enable, so it stays stable under stall.
  always_comb begin
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_address    = '0;
    bus_byteenable = '0;
    bus_writedata  = '0;
    case (r_state)
      FETCH:
        if (!w_halt) begin
          bus_read       = 1'b1;
          bus_address    = {pc_in[31:2], 2'b00};
          bus_byteenable = 4'hF;
        end
      MEM:
        if (mem_read_req) begin
          bus_read       = 1'b1;
          bus_address    = {dp_data_address[31:2], 2'b00};
          bus_byteenable = 4'hF;
        end else if (mem_write_req) begin
          bus_write      = 1'b1;
          bus_address    = {dp_data_address[31:2], 2'b00};
          bus_byteenable = w_st_be;
          bus_writedata  = w_st_wd;
        end
      default: ;
    endcase
  end

`ifdef MEM_BUS_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;

  assign w_to = (bus_read | bus_write) & bus_waitrequest &
                (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_to) r_timeout <= 1'b1;
      if ((bus_read | bus_write) && bus_waitrequest) r_to_cnt <= r_to_cnt + 1'b1;
      else                                           r_to_cnt <= '0;
    end
  end

  assign timeout_err = r_timeout;
`else
  logic w_unused_to;
  assign w_unused_to = (TIMEOUT_CYCLES == 0);
  assign w_to        = 1'b0;
  assign timeout_err = 1'b0;
`endif

  assign instr_readdata = r_instr;
  assign data_readdata  = r_data;
  assign clk_enable     = r_clk_en;
  assign active         = r_active;

endmodule
